tmr_error_collector: RTL
========================

Name: tmr_error_collector

Overview:
- Receiving end of the tmrError flags that triplicated modules and their voters raise.
- Captures a rising edge on each of NSRC error sources and keeps per-source sticky status.
- Counts error cycles in a saturating counter.
- Reports each captured event, one at a time, over a valid/ready readout toward the slow-control / monitoring logic.
- Sits at the top of a TMR design, one instance per clock domain.

Parameters:
- NSRC, 11, number of error sources (one bit per voter group).
- CNT_W, 16, width of the total error counter; the counter saturates at its maximum.
- IDX_W, $clog2(NSRC), width of the source index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- err_i  input  NSRC  level tmrError flags from the voters, synchronous to clk.
- clear_i  input  1  single-cycle clear of sticky bits, pending bits, counter and lost flag.
- evt_valid_o  output  1  an event is presented.
- evt_ready_i  input  1  consumer accepts the event.
- evt_src_o  output  IDX_W  source index of the presented event.
- evt_cnt_o  output  CNT_W  total_cnt_o value captured when the event was presented.
- sticky_o  output  NSRC  per-source "has ever erred since clear".
- total_cnt_o  output  CNT_W  saturating count of cycles with at least one rising edge.
- any_err_o  output  1  OR of err_i, registered.
- lost_o  output  1  sticky; an edge arrived on a source whose pending bit was already set.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs are 0, the err_d history is 0, pending is 0, the round-robin pointer is 0 and the FSM is IDLE.
- Edge detect: rise[k] = err_i[k] & ~err_d[k]; err_d is err_i delayed by one cycle. A level held high counts once.
- Per cycle, with rise != 0:
  - sticky |= rise and pending |= rise.
  - total_cnt_o increments by 1, regardless of how many bits rose; it holds at 2^CNT_W-1.
  - If rise[k] and pending[k] are both already set and k is not being accepted this cycle, lost_o is set.
- any_err_o is |err_i registered, giving 1-cycle latency.
- FSM has two states:
  - IDLE: if pending != 0, grant the first set bit searching upward from the pointer (wrapping modulo NSRC). Load evt_src_o, load evt_cnt_o with the post-update total_cnt_o, assert evt_valid_o next cycle, and go to PRESENT.
  - PRESENT: evt_valid_o, evt_src_o and evt_cnt_o stay stable until evt_ready_i=1. On the handshake, clear pending[evt_src_o], set pointer = (evt_src_o+1) mod NSRC, and go to IDLE, so evt_valid_o is 0 in the next cycle.
- Throughput is one event every 2 cycles. Minimum latency from an err_i rising edge to evt_valid_o is 2 cycles: edge in cycle t, pending set at the end of t, grant in t+1, valid in t+2.
- If a new edge on the source being accepted arrives in the handshake cycle, pending for that source stays set (it is re-armed) and lost_o is not set.
- clear_i=1:
  - Clears sticky, pending, total_cnt_o and lost_o, and returns the FSM to IDLE. evt_valid_o drops next cycle and the presented event is discarded.
  - Edges in the same cycle as clear_i win: their sticky and pending bits are set and total_cnt_o becomes 1.
  - The pointer is not reset.
- rst has priority over clear_i. Mid-handshake reset discards everything.
- evt_ready_i while evt_valid_o=0 is ignored.

Decomposition:
- Shared package tmr_mon_pkg holds:
  - FSM state enum {IDLE, PRESENT};
  - localparam function clog2 helper;
  - event struct {src, cnt}, reused by the future readout bridge.
- Sub-module rr_arbiter (NSRC-wide request vector plus pointer in; one-hot grant and index out; combinational, pointer kept in the parent).
- The collector itself must not be triplicated: mark it "tmrg do_not_triplicate".

Test Plan:
1. Reset, then err_i=0 for 10 cycles -> all outputs stay 0, evt_valid_o never asserts.
2. err_i[3] rises and is held high for 20 cycles, evt_ready_i=1 -> exactly one event with src=3 and cnt=1, valid 2 cycles after the edge. sticky_o=0x008, total_cnt_o=1.
3. err_i[0], err_i[5] and err_i[10] rise in the same cycle, evt_ready_i=0 for 5 cycles then 1 -> valid held stable with src=0 throughout the stall. Events follow in order 0, 5, 10, all with cnt=1. total_cnt_o=1.
4. Pulse err_i[2] twice, 3 cycles apart, while a stall holds pending[2] -> lost_o=1 and total_cnt_o=2. After clear_i: lost_o, sticky_o and total_cnt_o are 0, and evt_valid_o is 0 one cycle later.
5. With CNT_W=4, generate 20 separate error pulses -> total_cnt_o saturates at 15 and does not wrap.
6. Assert clear_i in the same cycle as an err_i[7] rising edge while an event is presented -> the old event is dropped, then an event with src=7 and cnt=1 is presented, and sticky_o=0x080.

Source files
------------

// File: rtl/tmr_mon_pkg.sv
// Shared types and helpers for the TMR error monitor.
// Holds the readout FSM encoding and the event record.
package tmr_mon_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int NSRC_DEF  = 11;
  localparam int CNT_W_DEF = 16;
  localparam int IDX_W_DEF = clog2(NSRC_DEF);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] src;
    logic [CNT_W_DEF-1:0] cnt;
  } evt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping modulo NSRC. The pointer register lives in the parent.
module rr_arbiter
  import tmr_mon_pkg::*;
#(
  parameter int NSRC  = 11,
  parameter int IDX_W = clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NSRC-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  function automatic logic [IDX_W-1:0] rot(
    input logic [IDX_W-1:0] p,
    input int               off
  );
    int s;
    s = int'(p) + off;
    if (s >= NSRC) s = s - NSRC;
    return s[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NSRC; i++) begin
      k = rot(ptr, i);
      if (!found && req[k]) begin
        found  = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmr_error_collector.sv
// Collects tmrError rising edges, keeps sticky/pending state and
// a saturating count, and streams one event at a time to readout.
// tmrg do_not_triplicate tmr_error_collector
module tmr_error_collector
  import tmr_mon_pkg::*;
#(
  parameter int NSRC  = 11,
  parameter int CNT_W = 16,
  parameter int IDX_W = clog2(NSRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  err_i,
  input  logic             clear_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W-1:0] evt_src_o,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic [NSRC-1:0]  sticky_o,
  output logic [CNT_W-1:0] total_cnt_o,
  output logic             any_err_o,
  output logic             lost_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [NSRC-1:0]  err_d, rise;
  logic [NSRC-1:0]  pending, pend_nxt;
  logic [NSRC-1:0]  evt_oh, acc_mask;
  logic [NSRC-1:0]  gnt;
  logic [IDX_W-1:0] ptr, ptr_nxt, gnt_idx;
  logic [CNT_W-1:0] cnt_nxt;
  logic             gnt_vld, accept, load, lost_set;

  rr_arbiter #(
    .NSRC  (NSRC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .found (gnt_vld)
  );

  assign rise     = err_i & ~err_d;
  // A clear in the handshake cycle discards the event instead
  assign accept   = evt_valid_o & evt_ready_i & ~clear_i;
  assign acc_mask = accept ? evt_oh : '0;
  assign lost_set = |(rise & pending & ~acc_mask);
  assign ptr_nxt  = (evt_src_o == IDX_W'(NSRC - 1)) ?
                    '0 : evt_src_o + 1'b1;

  always_comb begin
    pend_nxt = (pending & ~acc_mask) | rise;
    cnt_nxt  = total_cnt_o;
    if (clear_i) begin
      pend_nxt = rise;
      cnt_nxt  = (|rise) ? CNT_W'(1) : '0;
    end else if ((|rise) && (total_cnt_o != CNT_MAX)) begin
      cnt_nxt = total_cnt_o + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_nxt = PRESENT;
          load      = 1'b1;
        end
      end
      PRESENT: begin
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear_i) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      err_d       <= '0;
      pending     <= '0;
      ptr         <= '0;
      evt_oh      <= '0;
      evt_valid_o <= 1'b0;
      evt_src_o   <= '0;
      evt_cnt_o   <= '0;
      sticky_o    <= '0;
      total_cnt_o <= '0;
      any_err_o   <= 1'b0;
      lost_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_d       <= err_i;
      pending     <= pend_nxt;
      evt_valid_o <= (state_nxt == PRESENT);
      total_cnt_o <= cnt_nxt;
      any_err_o   <= |err_i;
      sticky_o    <= clear_i ? rise : (sticky_o | rise);
      lost_o      <= clear_i ? 1'b0 : (lost_o | lost_set);
      if (load) begin
        evt_src_o <= gnt_idx;
        evt_cnt_o <= cnt_nxt;
        evt_oh    <= gnt;
      end
      if (accept) ptr <= ptr_nxt;
    end
  end

endmodule
